// File: rtl/kbd_mmio_port.sv
// PS/2 keyboard receiver with a 2**FIFO_AW-entry scancode FIFO behind a 4-word MMIO window.
// Latency: PS/2 clock pin fall to FSM action is 3 clk; the byte is readable the cycle after the push; irq follows one cycle later.
// Backpressure: there is none toward the PS/2 device. A byte pushed while full is dropped and sets sticky overflow. A pop occurs only when hold is low.
//
// Ports:
//   clk, rst           pipeline clock; asynchronous active-low reset
//   ps2_clk, ps2_data  raw PS/2 pins, asynchronous to clk
//   sel, rd, wr, hold  window select, read/write strobes, pipeline stall
//   addr               word offset: 0 DATA (read pops), 1 STATUS (write clears flags), 2/3 read 0
//   rdata              combinational read data, 0 when !sel
//   irq                registered FIFO-nonempty
module kbd_mmio_port #(
    parameter int FIFO_AW        = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        sel,
    input  logic        rd,
    input  logic        wr,
    input  logic        hold,
    input  logic [1:0]  addr,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    // Pin synchronisers. They reset to 1, the PS/2 idle level, so that reset does not create a false edge.
    logic [1:0] ck_sync, dt_sync;
    logic       ck_prev;
    logic       fall, bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ck_sync <= 2'b11;
            dt_sync <= 2'b11;
            ck_prev <= 1'b1;
        end else begin
            ck_sync <= {ck_sync[0], ps2_clk};
            dt_sync <= {dt_sync[0], ps2_data};
            ck_prev <= ck_sync[1];
        end
    end

    assign fall   = ck_prev & ~ck_sync[1];
    assign bit_in = dt_sync[1];

    // Frame FSM
    state_t         state, state_nxt;
    logic [7:0]     sr;
    logic [2:0]     bcnt;
    logic           perr;
    logic [TW-1:0]  tcnt;
    logic           push_req, perr_set, ferr_set, to_hit;

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        to_hit    = (state != S_IDLE) && !fall && (tcnt == TO_MAX);
        case (state)
            S_IDLE:   if (fall && !bit_in) state_nxt = S_DATA;
            S_DATA:   if (fall && bcnt == 3'd7) state_nxt = S_PARITY;
            S_PARITY: if (fall) state_nxt = S_STOP;
            S_STOP: begin
                if (fall) begin
                    push_req  = bit_in & ~perr;
                    perr_set  = perr;
                    ferr_set  = ~bit_in;
                    state_nxt = S_IDLE;
                end
            end
            default:  state_nxt = S_IDLE;
        endcase
        // A stalled frame is abandoned, so the next start bit is not taken as data.
        if (to_hit) begin
            state_nxt = S_IDLE;
            ferr_set  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            sr    <= '0;
            bcnt  <= '0;
            perr  <= 1'b0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            if (to_hit) begin
                sr <= '0;
            end else if (fall) begin
                case (state)
                    S_IDLE:   bcnt <= '0;
                    S_DATA: begin
                        sr   <= {bit_in, sr[7:1]};
                        bcnt <= bcnt + 3'd1;
                    end
                    S_PARITY: perr <= ~^{sr, bit_in};
                    default:  ;
                endcase
            end
            if (fall || state == S_IDLE)
                tcnt <= '0;
            else if (tcnt != TO_MAX)
                tcnt <= tcnt + TW'(1);
        end
    end

    // Scancode FIFO
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               nonempty, full, pop, push, clr;
    logic               overflow, parity_err, frame_err;

    assign nonempty = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = sel & rd & ~hold & (addr == 2'd0) & nonempty;
    // A pop in the same edge frees a slot, so a push into a full FIFO is still accepted.
    assign push     = push_req & (~full | pop);
    assign clr      = sel & wr & ~hold & (addr == 2'd1);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            irq        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            // A new event wins over a clear in the same cycle.
            overflow   <= (overflow   & ~clr) | (push_req & full & ~pop);
            parity_err <= (parity_err & ~clr) | perr_set;
            frame_err  <= (frame_err  & ~clr) | ferr_set;
            irq        <= nonempty;
        end
    end

    // Read mux
    logic [31:0] status;

    always_comb begin
        status             = '0;
        status[0]          = nonempty;
        status[1]          = full;
        status[2]          = overflow;
        status[3]          = parity_err;
        status[4]          = frame_err;
        status[8 +: CW]    = count;
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                2'd0:    if (nonempty) rdata = {23'd0, 1'b1, mem[rd_ptr]};
                2'd1:    rdata = status;
                default: rdata = '0;
            endcase
        end
    end
endmodule
